// File: rtl/pic.sv
// pic: fixed-priority 8-input programmable interrupt controller.
// Latches rising edges on iIrq into IRR, masks them with IMR, and arbitrates
// with IRQ0 highest. oIntr is raised to the CPU. On iInta the winner's vector
// is returned and its ISR bit is set until an EOI is written to port 0x20.
// Build option: define PIC_AUTO_EOI_EN for auto-EOI. In that build ISR is
// never set and EOI commands have no effect.
module pic #(
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic [7:0] iIrq,
    input  logic       iWr,
    input  logic       iRd,
    input  logic       iAddr,
    input  logic [7:0] iData,
    output logic [7:0] oData,
    output logic       oIntr,
    input  logic       iInta,
    output logic [7:0] oVector,
    output logic       oVectorValid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic       rdsel_q, rdsel_d;     // 0: port 0 reads IRR, 1: reads ISR
    logic [7:0] data_q, data_d;
    logic [7:0] vector_q, vector_d;
    logic       vvalid_q, vvalid_d;

    logic [7:0] pending;
    logic [7:0] pend_low;             // one-hot of the winning request
    logic [7:0] win_mask;             // ones at every index <= winner
    logic [2:0] win;
    logic       serviceable;
    logic       ack_go;
    logic       spurious;
    logic       wr_cmd;
    logic       wr_mask;

    // Arbitration: lowest pending index wins unless an ISR bit at or below it is set
    always_comb begin
        pending     = irr_q & ~imr_q;
        pend_low    = pending & (~pending + 8'd1);
        win_mask    = pend_low | (pend_low - 8'd1);
        win         = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                win = 3'(i);
            end
        end
        serviceable = (|pending) && ((isr_q & win_mask) == 8'h00);
    end

    // FSM state register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: REQ holds only while the request stays serviceable
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (serviceable) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (iInta && serviceable) begin
                    state_d = ST_ACK;
                end else if (!serviceable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: interrupt line and acknowledge qualification
    always_comb begin
        oIntr    = (state_q == ST_REQ);
        ack_go   = (state_q == ST_REQ) && iInta && serviceable;
        // An acknowledge with nothing to grant (outside ACK) returns the IRQ7 vector
        spurious = iInta && (state_q != ST_ACK) && !ack_go;
    end

`ifndef PIC_AUTO_EOI_EN
    logic [7:0] isr_low;
    logic [7:0] eoi_clr;

    // EOI decode: non-specific clears the lowest in-service bit, specific clears bit n
    always_comb begin
        isr_low = isr_q & (~isr_q + 8'd1);
        eoi_clr = 8'h00;
        if (wr_cmd) begin
            if (iData == 8'h20) begin
                eoi_clr = isr_low;
            end else if (iData[7:3] == 5'b01100) begin
                eoi_clr = 8'h01 << iData[2:0];
            end
        end
    end
`endif

    // Register file, read port and vector next-state
    always_comb begin
        wr_cmd  = iWr && !iAddr;
        wr_mask = iWr && iAddr;

        prev_d = iIrq;

        // Clear the acknowledged request first so a same-cycle edge re-pends it
        irr_d = irr_q;
        if (ack_go) begin
            irr_d = irr_d & ~pend_low;
        end
        irr_d = irr_d | (iIrq & ~prev_q);

`ifdef PIC_AUTO_EOI_EN
        isr_d = 8'h00;
`else
        // EOI clears are applied before the ack set so the set wins on a collision
        isr_d = (isr_q & ~eoi_clr) | (ack_go ? pend_low : 8'h00);
`endif

        imr_d = wr_mask ? iData : imr_q;

        rdsel_d = rdsel_q;
        if (wr_cmd && (iData == 8'h0A)) begin
            rdsel_d = 1'b0;
        end else if (wr_cmd && (iData == 8'h0B)) begin
            rdsel_d = 1'b1;
        end

        // A read colliding with a write is dropped
        data_d = data_q;
        if (iRd && !iWr) begin
            if (iAddr) begin
                data_d = imr_q;
            end else begin
                data_d = rdsel_q ? isr_q : irr_q;
            end
        end

        vector_d = vector_q;
        vvalid_d = 1'b0;
        if (ack_go) begin
            vector_d = VECTOR_BASE + {5'd0, win};
            vvalid_d = 1'b1;
        end else if (spurious) begin
            vector_d = VECTOR_BASE + 8'd7;
            vvalid_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            prev_q   <= 8'h00;
            irr_q    <= 8'h00;
            isr_q    <= 8'h00;
            imr_q    <= 8'hFF;
            rdsel_q  <= 1'b0;
            data_q   <= 8'h00;
            vector_q <= 8'h00;
            vvalid_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            rdsel_q  <= rdsel_d;
            data_q   <= data_d;
            vector_q <= vector_d;
            vvalid_q <= vvalid_d;
        end
    end

    assign oData        = data_q;
    assign oVector      = vector_q;
    assign oVectorValid = vvalid_q;

endmodule

// File: tb/tb_pic.sv
// tb_pic: scoreboard bench for pic. Stimulus pushes expected vectors and read
// data into queues; a monitor pops and compares whenever the DUT presents them.
// The reference model keeps IRR/ISR/IMR as plain variables updated per operation.
module tb_pic;

    localparam logic [7:0] VB = 8'h08;

    logic       iClk = 1'b0;
    logic       iRstN;
    logic [7:0] iIrq;
    logic       iWr, iRd, iAddr, iInta;
    logic [7:0] iData;
    logic [7:0] oData, oVector;
    logic       oIntr, oVectorValid;

    int errors = 0;
    int checks = 0;

    logic [7:0] vec_q[$];
    logic [7:0] rd_q[$];
    logic       rd_seen;

    logic [7:0] m_irr, m_isr, m_imr;
    logic       m_rdsel;

    pic #(.VECTOR_BASE(VB)) dut (
        .iClk(iClk), .iRstN(iRstN), .iIrq(iIrq), .iWr(iWr), .iRd(iRd),
        .iAddr(iAddr), .iData(iData), .oData(oData), .oIntr(oIntr),
        .iInta(iInta), .oVector(oVector), .oVectorValid(oVectorValid)
    );

    always #50 iClk = ~iClk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Remember whether a read was issued so its data is checked one cycle later
    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN) rd_seen <= 1'b0;
        else        rd_seen <= iRd & ~iWr;
    end

    // Monitor: compare every presented vector and read result against the queues
    always @(negedge iClk) begin
        if (oVectorValid === 1'b1) begin
            if (vec_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vector_unexpected: got %02h expected none", oVector);
            end else begin
                check8("vector", oVector, vec_q.pop_front());
            end
        end
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_unexpected: got %02h expected none", oData);
            end else begin
                check8("read_data", oData, rd_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int lowest(input logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[i]) return i;
        return 8;
    endfunction

    function automatic bit m_serv();
        int w;
        w = lowest(m_irr & ~m_imr);
        if (w == 8) return 1'b0;
        for (int i = 0; i <= w; i++) if (m_isr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_write(input logic a, input logic [7:0] d);
        if (a) begin
            m_imr = d;
        end else if (d == 8'h20) begin
            if (m_isr != 8'h00) m_isr[lowest(m_isr)] = 1'b0;
        end else if (d >= 8'h60 && d <= 8'h67) begin
            m_isr[d[2:0]] = 1'b0;
        end else if (d == 8'h0A) begin
            m_rdsel = 1'b0;
        end else if (d == 8'h0B) begin
            m_rdsel = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_rdsel = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge iClk); #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic a, input logic [7:0] d);
        model_write(a, d);
        iWr = 1'b1; iAddr = a; iData = d;
        tick();
        iWr = 1'b0;
    endtask

    task automatic do_read(input logic a);
        rd_q.push_back(a ? m_imr : (m_rdsel ? m_isr : m_irr));
        iRd = 1'b1; iAddr = a;
        tick();
        iRd = 1'b0;
    endtask

    task automatic read_irr();
        do_write(1'b0, 8'h0A);
        do_read(1'b0);
    endtask

    task automatic read_isr();
        do_write(1'b0, 8'h0B);
        do_read(1'b0);
    endtask

    task automatic pulse(input logic [7:0] m);
        m_irr = m_irr | m;
        iIrq = m;
        tick();
        iIrq = 8'h00;
    endtask

    // Acknowledge, optionally with a same-cycle edge and/or write
    task automatic do_ack(input logic [7:0] irq_m, input logic wr, input logic a,
                          input logic [7:0] d);
        int   w;
        bit   grant;
        grant = m_serv();
        w     = lowest(m_irr & ~m_imr);
        if (grant) vec_q.push_back(VB + 8'(w));
        else       vec_q.push_back(VB + 8'd7);
        iInta = 1'b1; iIrq = irq_m; iWr = wr; iAddr = a; iData = d;
        tick();
        iInta = 1'b0; iIrq = 8'h00; iWr = 1'b0;
        if (grant) m_irr[w] = 1'b0;
        m_irr = m_irr | irq_m;
        if (wr) model_write(a, d);
`ifndef PIC_AUTO_EOI_EN
        if (grant) m_isr[w] = 1'b1;
`endif
    endtask

    task automatic check_intr(input string name);
        check8(name, {7'd0, oIntr}, {7'd0, m_serv()});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        iRstN = 1'b0; iIrq = 8'h00; iWr = 1'b0; iRd = 1'b0; iAddr = 1'b0;
        iData = 8'h00; iInta = 1'b0;
        model_reset();
        #130;
        check8("rst_intr", {7'd0, oIntr}, 8'h00);
        check8("rst_data", oData, 8'h00);
        check8("rst_vector", oVector, 8'h00);
        check8("rst_vvalid", {7'd0, oVectorValid}, 8'h00);
        @(negedge iClk); iRstN = 1'b1;
        tick();

        // Basic timer interrupt with exact request/ack latency
        do_write(1'b1, 8'hFE);
        pulse(8'h01);
        check8("req_lat_t1", {7'd0, oIntr}, 8'h00);
        tick();
        check8("req_lat_t2", {7'd0, oIntr}, 8'h01);
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        check8("intr_in_ack", {7'd0, oIntr}, 8'h00);
        settle(4);
        read_isr();
        read_irr();
        do_write(1'b0, 8'h20);
        settle(3);

        // Priority and nesting
        do_write(1'b1, 8'h00);
        pulse(8'h0A);
        settle(4);
        check_intr("nest_req");
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        settle(4);
        check_intr("nest_blocked");
        do_write(1'b0, 8'h20);
        settle(4);
        check_intr("nest_after_eoi");
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        settle(4);
        do_write(1'b0, 8'h20);
        settle(3);

        // Masking
        do_write(1'b1, 8'hFF);
        pulse(8'h04);
        settle(4);
        check_intr("mask_hold");
        read_irr();
        do_write(1'b1, 8'hFB);
        settle(4);
        check_intr("mask_open");
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        settle(4);
        do_write(1'b0, 8'h20);
        settle(4);

        // Spurious acknowledge
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        settle(3);
        read_irr();
        read_isr();

        // Same-cycle edge during ack re-pends; EOI targeting the set bit loses
        do_write(1'b1, 8'h00);
        pulse(8'h20);
        settle(4);
        do_ack(8'h20, 1'b0, 1'b0, 8'h00);
        settle(3);
        read_irr();
        read_isr();
        do_write(1'b0, 8'h65);
        settle(4);
        check_intr("repend_req");
        do_ack(8'h00, 1'b1, 1'b0, 8'h65);
        settle(3);
        read_isr();
        do_write(1'b0, 8'h20);
        settle(3);

        // IMR write in the ack cycle: arbitration uses the old mask
        pulse(8'h04);
        settle(4);
        do_ack(8'h00, 1'b1, 1'b1, 8'hFF);
        settle(3);
        do_read(1'b1);
        check_intr("imr_collide");

        // Randomised operations
        for (int n = 0; n < 250; n++) begin
            int op;
            op = int'($urandom_range(0, 8));
            case (op)
                0, 1: pulse(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
                2:    do_write(1'b1, 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
                3, 4: do_ack(8'h00, 1'b0, 1'b0, 8'h00);
                5:    do_write(1'b0, 8'h20);
                6:    do_write(1'b0, 8'h60 | 8'($urandom_range(0, 7)));
                7:    if ($urandom_range(0, 1) == 1) read_irr(); else read_isr();
                default: do_read(1'b1);
            endcase
            settle(4);
            check_intr("rand_intr");
        end

        // Reset in the middle of a handshake
        for (int i = 0; i < 8; i++) do_write(1'b0, 8'h60 | 8'(i));
        do_write(1'b1, 8'h00);
        pulse(8'h01);
        settle(4);
        check_intr("pre_reset_req");
        #20 iRstN = 1'b0;
        #1;
        check8("midrst_intr", {7'd0, oIntr}, 8'h00);
        check8("midrst_data", oData, 8'h00);
        check8("midrst_vector", oVector, 8'h00);
        check8("midrst_vvalid", {7'd0, oVectorValid}, 8'h00);
        model_reset();
        @(negedge iClk); iRstN = 1'b1;
        tick();
        do_read(1'b1);
        read_irr();

        // Back-to-back IRQ0 service; in the auto-EOI build ISR stays clear
        do_write(1'b1, 8'hFE);
        pulse(8'h01);
        settle(4);
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        settle(4);
        read_isr();
        pulse(8'h01);
        settle(4);
        check_intr("second_irq0");
        do_ack(8'h00, 1'b0, 1'b0, 8'h00);
        settle(4);

        checks++;
        if (vec_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d vectors %0d reads outstanding expected 0 0",
                     vec_q.size(), rd_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
